// File: rtl/df_mult_c3.sv
// df_mult_c3: pipelined constant multiplier for filter tap 3.
// Computes data_out = floor(data_in * COEF / 2^W) with COEF as an unsigned Q0.W value.
// A fixed shift-and-add tree replaces the multiplier: four partial products,
// two 3:2 carry-save levels, then one carry-propagate add.
// The pipeline depth is four registers, so a sample appears four rising edges after it is taken.
module df_mult_c3 #(
  parameter int         W    = 8,
  parameter logic [7:0] COEF = 8'h1B
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  output logic [W-1:0] data_out
);

  localparam int PW = 2 * W;

  // Sum bit of a 3:2 carry-save compressor
  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] a,
                                            input logic [PW-1:0] b,
                                            input logic [PW-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Carry bit of a 3:2 carry-save compressor, already weighted by one position
  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b,
                                              input logic [PW-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  // Drops the W fractional bits of the Q0.W product (floor, no rounding).
  // The product never exceeds the output range, so no saturation is needed
  function automatic logic [W-1:0] trunc_q(input logic [PW-1:0] p);
    return W'(p >> W);
  endfunction

  logic [PW-1:0] ext_d;
  logic [PW-1:0] s1_p0 [0:3];
  logic          vld_p0;
  logic [PW-1:0] s2_p1 [0:2];
  logic          vld_p1;
  logic [PW-1:0] s3_p2 [0:1];
  logic          vld_p2;

  assign ext_d = {{W{1'b0}}, data_in};

  // Stage p0: partial products for coefficient bits 0, 1, 3 and 4
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      s1_p0[0] <= '0;
      s1_p0[1] <= '0;
      s1_p0[2] <= '0;
      s1_p0[3] <= '0;
    end else begin
      vld_p0   <= in_valid;
      s1_p0[0] <= COEF[0] ? ext_d       : '0;
      s1_p0[1] <= COEF[1] ? ext_d << 1  : '0;
      s1_p0[2] <= COEF[3] ? ext_d << 3  : '0;
      s1_p0[3] <= COEF[4] ? ext_d << 4  : '0;
    end
  end

  // Stage p1: first carry-save level; fourth partial product passes through
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      s2_p1[0] <= '0;
      s2_p1[1] <= '0;
      s2_p1[2] <= '0;
    end else begin
      vld_p1   <= vld_p0;
      s2_p1[0] <= csa_sum(s1_p0[0], s1_p0[1], s1_p0[2]);
      s2_p1[1] <= csa_carry(s1_p0[0], s1_p0[1], s1_p0[2]);
      s2_p1[2] <= s1_p0[3];
    end
  end

  // Stage p2: second carry-save level leaves a sum/carry pair
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      s3_p2[0] <= '0;
      s3_p2[1] <= '0;
    end else begin
      vld_p2   <= vld_p1;
      s3_p2[0] <= csa_sum(s2_p1[0], s2_p1[1], s2_p1[2]);
      s3_p2[1] <= csa_carry(s2_p1[0], s2_p1[1], s2_p1[2]);
    end
  end

  // Output stage: carry-propagate add and truncation; data holds while invalid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        data_out <= trunc_q(s3_p2[0] + s3_p2[1]);
      end
    end
  end

endmodule

// File: tb/tb_df_mult_c3.sv
// Bench for df_mult_c3: drives samples, pushes expected results with their due
// cycle into a scoreboard queue and pops them as out_valid appears.
module tb_df_mult_c3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       out_valid;
  logic [7:0] data_out;

  typedef struct {
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic rst_q  = 1'b1;
  logic [7:0] last_out = 8'd0;

  df_mult_c3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus; a valid sample is expected 4 edges later
  task automatic send(input logic [7:0] d, input logic v, input logic [7:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    in_valid = v;
    data_in  = d;
    if (v) begin
      x.d   = e;
      x.due = cyc + 4;
      q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(8'd0, 1'b0, 8'd0);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out", data_out, 0);
      last_out = 8'd0;
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("missing_output_due", cyc, q[0].due);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data_out", data_out, e.d);
          chk("latency_cycle", cyc, e.due);
        end
        last_out = data_out;
      end else begin
        chk("hold_data_out", data_out, last_out);
      end
    end
  end

  logic [7:0] single_in  [6] = '{8'd0, 8'd51, 8'd102, 8'd153, 8'd204, 8'd255};
  logic [7:0] single_exp [6] = '{8'd0, 8'd5,  8'd10,  8'd16,  8'd21,  8'd26};

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    #2;
    chk("post_reset_out_valid", out_valid, 0);
    chk("post_reset_data_out", data_out, 0);

    // Isolated single samples
    for (int i = 0; i < 6; i++) begin
      send(single_in[i], 1'b1, single_exp[i]);
      idle(5);
    end

    // Same values streamed back to back
    for (int i = 0; i < 6; i++) send(single_in[i], 1'b1, single_exp[i]);
    idle(6);

    // Exhaustive stream against a multiply-based reference
    for (int d = 0; d < 256; d++) begin
      int p;
      p = (d * 27) >> 8;
      send(8'(d), 1'b1, 8'(p));
    end
    idle(6);

    // Reset with three samples in flight: all are flushed
    send(8'd255, 1'b1, 8'd26);
    send(8'd204, 1'b1, 8'd21);
    send(8'd153, 1'b1, 8'd16);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(8);

    // Gap in valid: 255, bubble, 51
    send(8'd255, 1'b1, 8'd26);
    send(8'd77,  1'b0, 8'd0);
    send(8'd51,  1'b1, 8'd5);
    idle(8);

    #2;
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
